// File: rtl/pulse_toggle_tx_if.sv
// Event/toggle handshake bundle between an event source and the toggle encoder.
interface pulse_toggle_tx_if #(
    parameter int unsigned CNT_W = 4
);
    logic             evt_in;
    logic             clr_ovf;
    logic             sig_tog;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;
    logic             idle;

    modport master (
        output evt_in,
        output clr_ovf,
        input  sig_tog,
        input  pend_cnt,
        input  ovf,
        input  idle
    );

    modport slave (
        input  evt_in,
        input  clr_ovf,
        output sig_tog,
        output pend_cnt,
        output ovf,
        output idle
    );
endinterface

// File: rtl/pulse_toggle_tx.sv
// Event-to-transition encoder: each accepted event becomes one sig_tog edge, with
// edges spaced at least GAP clocks apart and a saturating backlog in between.
module pulse_toggle_tx #(
    parameter int unsigned GAP   = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_toggle_tx_if.slave   bus_io
);
    localparam logic [0:0]       StIdle  = 1'b0;
    localparam logic [0:0]       StHold  = 1'b1;
    localparam logic [7:0]       GapM1   = 8'(GAP - 1);
    localparam logic [CNT_W-1:0] PendMax = {CNT_W{1'b1}};

    if (GAP < 2 || GAP > 255) begin : g_gap_check
        $error("pulse_toggle_tx: GAP must be within 2..255");
    end

    logic [0:0]       state_q, state_d;
    logic             tog_q, tog_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       gap_q, gap_d;
    logic             drop;
    logic [CNT_W:0]   eff;

    // One bit wider so a full backlog plus a new event does not wrap.
    assign eff = {1'b0, pend_q} + {{CNT_W{1'b0}}, bus_io.evt_in};

    always_comb begin
        state_d = state_q;
        tog_d   = tog_q;
        pend_d  = pend_q;
        gap_d   = gap_q;
        drop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (eff != '0) begin
                    tog_d   = ~tog_q;
                    pend_d  = CNT_W'(eff - {{CNT_W{1'b0}}, 1'b1});
                    gap_d   = GapM1;
                    state_d = StHold;
                end
            end
            StHold: begin
                gap_d = gap_q - 8'd1;
                if (bus_io.evt_in) begin
                    if (pend_q != PendMax) begin
                        pend_d = pend_q + 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (gap_q == 8'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop | (ovf_q & ~bus_io.clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tog_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            tog_q   <= tog_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            gap_q   <= gap_d;
        end
    end

    assign bus_io.sig_tog  = tog_q;
    assign bus_io.pend_cnt = pend_q;
    assign bus_io.ovf      = ovf_q;
    assign bus_io.idle     = (state_q == StIdle) && (pend_q == '0);
endmodule

// File: tb/tb_pulse_toggle_tx.sv
// Bench for pulse_toggle_tx: three configurations share one stimulus stream and are
// compared each edge against a timestamp-based model, plus fixed vectors and sequences.
module tb_pulse_toggle_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic evt = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    pulse_toggle_tx_if #(.CNT_W(4)) if_a ();
    pulse_toggle_tx_if #(.CNT_W(2)) if_b ();
    pulse_toggle_tx_if #(.CNT_W(4)) if_c ();

    assign if_a.evt_in  = evt;
    assign if_a.clr_ovf = clr;
    assign if_b.evt_in  = evt;
    assign if_b.clr_ovf = clr;
    assign if_c.evt_in  = evt;
    assign if_c.clr_ovf = clr;

    pulse_toggle_tx #(.GAP(4), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus_io(if_a));
    pulse_toggle_tx #(.GAP(4), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus_io(if_b));
    pulse_toggle_tx #(.GAP(2), .CNT_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus_io(if_c));

    // Model: a toggle may fire at edge t when t >= last toggle edge + gap.
    typedef struct {
        int backlog;
        int last;
        bit tog;
        bit ovf;
    } mst_t;

    typedef struct {
        bit rst;
        bit evt;
        bit clr;
        bit tog;
        int pend;
        bit ovf;
        bit idle;
    } vec_t;

    mst_t ma, mb, mc;
    int   t = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[26];

    function automatic mst_t mstep(mst_t s, int gap, int maxc, int tt, bit r, bit e, bit c);
        mst_t n;
        bit   drop;
        n    = s;
        drop = 1'b0;
        if (!r) begin
            n.backlog = 0;
            n.last    = -1000;
            n.tog     = 1'b0;
            n.ovf     = 1'b0;
            return n;
        end
        if (tt >= s.last + gap && s.backlog + int'(e) > 0) begin
            n.tog     = ~s.tog;
            n.last    = tt;
            n.backlog = s.backlog + int'(e) - 1;
        end else if (e) begin
            if (s.backlog < maxc) n.backlog = s.backlog + 1;
            else drop = 1'b1;
        end
        n.ovf = drop | (s.ovf & ~c);
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, t);
        end
    endtask

    task automatic cmp_model(input string tag, input mst_t m, input int gap, input bit tog,
                             input int pend, input bit ovf, input bit idle);
        chk({tag, ".sig_tog"}, int'(tog), int'(m.tog));
        chk({tag, ".pend_cnt"}, pend, m.backlog);
        chk({tag, ".ovf"}, int'(ovf), int'(m.ovf));
        chk({tag, ".idle"}, int'(idle), int'((t + 1 >= m.last + gap) && (m.backlog == 0)));
    endtask

    // One clock edge: drive, advance models, sample #1 after the edge.
    task automatic step(input bit r, input bit e, input bit c);
        @(negedge clk);
        rst_n = r;
        evt   = e;
        clr   = c;
        @(posedge clk);
        ma = mstep(ma, 4, 15, t, r, e, c);
        mb = mstep(mb, 4, 3, t, r, e, c);
        mc = mstep(mc, 2, 15, t, r, e, c);
        #1;
        cmp_model("a", ma, 4, if_a.sig_tog, int'(if_a.pend_cnt), if_a.ovf, if_a.idle);
        cmp_model("b", mb, 4, if_b.sig_tog, int'(if_b.pend_cnt), if_b.ovf, if_b.idle);
        cmp_model("c", mc, 2, if_c.sig_tog, int'(if_c.pend_cnt), if_c.ovf, if_c.idle);
        t++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int   ntog;
        bit   prev;
        int   pend_a[8];
        bit   tog_c[10];
        int   pend_c[10];

        // Saturation with CNT_W=2, GAP=4; row 0 is reset, rows 1..25 are edges 0..24.
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 1, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 2, 0, 0};
        tbl[4]  = '{1, 1, 0, 1, 3, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 3, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 3, 1, 0};
        tbl[7]  = '{1, 1, 0, 0, 3, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 3, 1, 0};
        tbl[9]  = '{1, 1, 0, 1, 3, 1, 0};
        tbl[10] = '{1, 1, 0, 1, 3, 1, 0};
        tbl[11] = '{1, 0, 0, 1, 3, 1, 0};
        tbl[12] = '{1, 0, 0, 1, 3, 1, 0};
        tbl[13] = '{1, 0, 0, 0, 2, 1, 0};
        tbl[14] = '{1, 0, 0, 0, 2, 1, 0};
        tbl[15] = '{1, 0, 0, 0, 2, 1, 0};
        tbl[16] = '{1, 0, 0, 0, 2, 1, 0};
        tbl[17] = '{1, 0, 0, 1, 1, 1, 0};
        tbl[18] = '{1, 0, 0, 1, 1, 1, 0};
        tbl[19] = '{1, 0, 0, 1, 1, 1, 0};
        tbl[20] = '{1, 0, 0, 1, 1, 1, 0};
        tbl[21] = '{1, 0, 0, 0, 0, 1, 0};
        tbl[22] = '{1, 0, 0, 0, 0, 1, 0};
        tbl[23] = '{1, 0, 0, 0, 0, 1, 0};
        tbl[24] = '{1, 0, 0, 0, 0, 1, 1};
        tbl[25] = '{1, 0, 0, 0, 0, 1, 1};

        pend_a = '{1, 2, 2, 1, 1, 1, 1, 0};
        tog_c  = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        pend_c = '{0, 1, 1, 2, 2, 2, 1, 1, 0, 0};

        ma = mstep(ma, 4, 15, 0, 1'b0, 1'b0, 1'b0);
        mb = ma;
        mc = ma;

        // Reset state
        do_reset();
        chk("rst_tog", int'(if_a.sig_tog), 0);
        chk("rst_pend", int'(if_a.pend_cnt), 0);
        chk("rst_ovf", int'(if_a.ovf), 0);
        chk("rst_idle", int'(if_a.idle), 1);

        // Single event at edge 10
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("single_tog", int'(if_a.sig_tog), 1);
        chk("single_idle_11", int'(if_a.idle), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("single_idle_12", int'(if_a.idle), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("single_idle_13", int'(if_a.idle), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("single_idle_14", int'(if_a.idle), 1);
        chk("single_pend", int'(if_a.pend_cnt), 0);

        // Burst of three on GAP=4, CNT_W=4
        do_reset();
        ntog = 0;
        prev = if_a.sig_tog;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i < 3, 1'b0);
            if (if_a.sig_tog != prev) ntog++;
            prev = if_a.sig_tog;
            if (i >= 1 && i <= 8) chk("burst_pend", int'(if_a.pend_cnt), pend_a[i-1]);
            if (i == 4 || i == 8) chk("burst_tog_edge", int'(if_a.sig_tog), i == 4 ? 0 : 1);
        end
        chk("burst_toggles", ntog, 3);

        // Saturation vectors on CNT_W=2
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rst, tbl[i].evt, tbl[i].clr);
            chk("vec_tog", int'(if_b.sig_tog), int'(tbl[i].tog));
            chk("vec_pend", int'(if_b.pend_cnt), tbl[i].pend);
            chk("vec_ovf", int'(if_b.ovf), int'(tbl[i].ovf));
            chk("vec_idle", int'(if_b.idle), int'(tbl[i].idle));
        end

        // Clear priority: drop and clr together keep ovf; clr alone clears it
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        chk("clr_pre_ovf", int'(if_b.ovf), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_with_drop", int'(if_b.ovf), 1);
        step(1'b1, 1'b0, 1'b1);
        chk("clr_alone", int'(if_b.ovf), 0);

        // Reset mid-burst at edge 6
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("midrst_tog", int'(if_b.sig_tog), 0);
        chk("midrst_pend", int'(if_b.pend_cnt), 0);
        chk("midrst_ovf", int'(if_b.ovf), 0);
        chk("midrst_idle", int'(if_b.idle), 1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("midrst_quiet_tog", int'(if_b.sig_tog), 0);

        // Minimum gap on GAP=2
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i < 5, 1'b0);
            chk("gap2_tog", int'(if_c.sig_tog), int'(tog_c[i]));
            chk("gap2_pend", int'(if_c.pend_cnt), pend_c[i]);
            chk("gap2_ovf", int'(if_c.ovf), 0);
        end

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199, 0) != 0, $urandom_range(99, 0) < 45,
                 $urandom_range(19, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
